// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns byte/half/word requests into aligned word
// accesses with load extension, read-modify-write sub-word stores and alignment checks.
module load_store_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Req,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       LoadData,
  output logic              Ack,
  output logic              AddrError,
  output logic              Stall,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemWriteData,
  output logic              MemWriteEn,
  output logic              MemReadEn,
  input  logic [31:0]       MemReadData
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       ld_q;

  logic              misaligned;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_d;
  logic [31:0]       merged;

  always_comb begin
    misaligned = (Size == 2'b11) ||
                 ((Size == 2'b01) && Address[0]) ||
                 ((Size == 2'b10) && (Address[1:0] != 2'b00));
  end

  // Lane selection and extension work only from latched request fields.
  always_comb begin
    rd_byte = MemReadData[{addr_q[1:0], 3'b000} +: 8];
    rd_half = MemReadData[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_d = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   ld_d = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: ld_d = MemReadData;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  // Memory-side strobes come from state alone so reset kills them instantly.
  always_comb begin
    MemReadEn    = (state_q == READ) || (state_q == RMW_RD);
    MemWriteEn   = (state_q == WRITE) || (state_q == RMW_WR);
    MemWriteData = (state_q == WRITE)  ? wdata_q :
                   (state_q == RMW_WR) ? merged  : '0;
    MemAddress   = {addr_q[ADDR_W-1:2], 2'b00};
    Ack          = (state_q == DONE);
    AddrError    = (state_q == DONE) && err_q;
    LoadData     = ld_q;
    Stall        = Req && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      ld_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req) begin
            addr_q  <= Address;
            size_q  <= Size;
            uns_q   <= Unsigned;
            wdata_q <= WriteData;
            if (misaligned) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else if (MemWrite) begin
              state_q <= (Size == 2'b10) ? WRITE : RMW_RD;
            end else if (MemRead) begin
              state_q <= READ;
            end else begin
              state_q <= DONE;
            end
          end
        end
        READ: begin
          ld_q    <= ld_d;
          state_q <= DONE;
        end
        WRITE:   state_q <= DONE;
        RMW_RD: begin
          merge_q <= MemReadData;
          state_q <= RMW_WR;
        end
        RMW_WR:  state_q <= DONE;
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        Req;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] LoadData;
  logic        Ack;
  logic        AddrError;
  logic        Stall;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWriteEn;
  logic        MemReadEn;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:15];
  int n_cmp;
  int n_bad;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Address(Address), .WriteData(WriteData),
    .LoadData(LoadData), .Ack(Ack), .AddrError(AddrError), .Stall(Stall),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWriteEn(MemWriteEn),
    .MemReadEn(MemReadEn), .MemReadData(MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Garbage when not enabled, so any sampling outside a read shows up.
  assign MemReadData = MemReadEn ? mem[MemAddress[5:2]] : 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (MemWriteEn) mem[MemAddress[5:2]] <= MemWriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input int exp_ack, input logic exp_err,
                      input logic [7:0] exp_ren, input logic [7:0] exp_wen,
                      input logic [31:0] exp_wd, input logic [31:0] exp_ma,
                      input logic [31:0] exp_ld);
    int          ack_c;
    logic        err;
    logic [7:0]  ren;
    logic [7:0]  wen;
    logic [31:0] wdo;
    logic [31:0] ma;
    logic [31:0] ld;
    ack_c = 0; err = 1'b0; ren = '0; wen = '0; wdo = '0; ma = '0; ld = '0;
    @(negedge clk);
    Req = 1'b1; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns;
    Address = addr; WriteData = wd;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 32'(Stall), (c == exp_ack) ? 32'd0 : 32'd1);
      if (MemReadEn) ren[c] = 1'b1;
      if (MemWriteEn) begin
        wen[c] = 1'b1;
        wdo = MemWriteData;
      end
      if (MemReadEn || MemWriteEn) ma = MemAddress;
      if (Ack) begin
        ack_c = c;
        err = AddrError;
        ld = LoadData;
        break;
      end
    end
    Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    chk({tag, "_ackcyc"}, 32'(ack_c), 32'(exp_ack));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_ren"}, 32'(ren), 32'(exp_ren));
    chk({tag, "_wen"}, 32'(wen), 32'(exp_wen));
    chk({tag, "_wdata"}, wdo, exp_wd);
    chk({tag, "_maddr"}, ma, exp_ma);
    chk({tag, "_ld"}, ld, exp_ld);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0; Req = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b00;
    Unsigned = 1'b0; Address = '0; WriteData = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_err", 32'(AddrError), 32'd0);
    chk("rst_wen", 32'(MemWriteEn), 32'd0);
    chk("rst_ren", 32'(MemReadEn), 32'd0);
    chk("rst_ld", LoadData, 32'd0);
    chk("rst_ma", MemAddress, 32'd0);
    chk("rst_wd", MemWriteData, 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    rst_n = 1'b1;

    //    tag        rd    wr    sz     uns  addr    wdata         ack err ren    wen    wdata         maddr   loaddata
    xfer("sw10",     1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 8'h00, 8'h02, 32'hDEADBEEF, 32'h10, 32'h0);
    xfer("lw10",     1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'hDEADBEEF);
    xfer("lb12",     1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'hFFFFFFAD);
    xfer("lbu12",    1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'h000000AD);
    xfer("lh12",     1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'hFFFFDEAD);
    xfer("lhu10",    1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'h0000BEEF);
    xfer("sb11",     1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, 3, 1'b0, 8'h02, 8'h04, 32'hDEAD55EF, 32'h10, 32'h0000BEEF);
    xfer("sh12",     1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hBBBB1234, 3, 1'b0, 8'h02, 8'h04, 32'h123455EF, 32'h10, 32'h0000BEEF);
    xfer("lw10b",    1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'h123455EF);
    xfer("lb13",     1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'h00000012);
    xfer("lw13",     1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        1, 1'b1, 8'h00, 8'h00, 32'h0,        32'h0,  32'h00000012);
    xfer("sh11",     1'b0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h00009999, 1, 1'b1, 8'h00, 8'h00, 32'h0,        32'h0,  32'h00000012);
    xfer("st_sz3",   1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1, 1'b1, 8'h00, 8'h00, 32'h0,        32'h0,  32'h00000012);
    xfer("ld_sz3",   1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1, 1'b1, 8'h00, 8'h00, 32'h0,        32'h0,  32'h00000012);
    xfer("noop",     1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1, 1'b0, 8'h00, 8'h00, 32'h0,        32'h0,  32'h00000012);
    chk("mem10_intact", mem[4], 32'h123455EF);
    xfer("rdwr20",   1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 2, 1'b0, 8'h00, 8'h02, 32'hCAFEF00D, 32'h20, 32'h00000012);
    xfer("lw20",     1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h20, 32'hCAFEF00D);

    // Reset while the sub-word store is in its write cycle.
    @(negedge clk);
    Req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Size = 2'b00; Unsigned = 1'b0;
    Address = 32'h14; WriteData = 32'h00000077;
    @(negedge clk);
    chk("rmw_rd_ren", 32'(MemReadEn), 32'd1);
    @(negedge clk);
    chk("rmw_wr_wen", 32'(MemWriteEn), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", 32'(MemWriteEn), 32'd0);
    chk("rst_mid_ack", 32'(Ack), 32'd0);
    Req = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk("rst_hold_ack", 32'(Ack), 32'd0);
    chk("rst_hold_ld", LoadData, 32'd0);
    chk("rst_hold_ma", MemAddress, 32'd0);
    rst_n = 1'b1;
    chk("mem14_intact", mem[5], 32'h0);
    xfer("lw_after", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 1'b0, 8'h02, 8'h00, 32'h0,        32'h10, 32'h123455EF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
